// File: rtl/imm_ext_ctrl_pkg.sv
// rtl/imm_ext_ctrl_pkg.sv - shared decode constants, immediate modes and FSM states
package imm_ext_ctrl_pkg;

  localparam int IMM_W = 16;

  localparam logic [3:0] PFX_OPC = 4'b1111;

  // Opcode groups are selected by opcode[3:2]
  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_MEM   = 2'b10;
  localparam logic [1:0] GRP_CTRL  = 2'b11;

  typedef enum logic [1:0] {
    ZERO     = 2'd0,
    SIGN     = 2'd1,
    SIGN_SH1 = 2'd2,
    PREFIX   = 2'd3
  } imm_mode_t;

  typedef enum logic {
    S_NORM = 1'b0,
    S_PFX  = 1'b1
  } state_t;

  function automatic imm_mode_t decode_mode(input logic [3:0] opc);
    imm_mode_t m;
    m = SIGN;
    if (opc == PFX_OPC) begin
      m = PREFIX;
    end else begin
      case (opc[3:2])
        GRP_ARITH: m = SIGN;
        GRP_LOGIC: m = ZERO;
        GRP_MEM:   m = SIGN;
        GRP_CTRL:  m = SIGN_SH1;
        default:   m = SIGN;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/imm_ext_ctrl_if.sv
// rtl/imm_ext_ctrl_if.sv - fetch-side and ID/EX-side handshake bundle for imm_ext_ctrl
interface imm_ext_ctrl_if;
  import imm_ext_ctrl_pkg::*;

  logic             in_valid;
  logic [IMM_W-1:0] in_instr;
  logic             in_ready;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [IMM_W-1:0] out_instr;
  logic [IMM_W-1:0] out_imm;
  logic             out_pfx;
  logic             pfx_err;

  // master: the surrounding pipeline (fetch + ID/EX); slave: the controller
  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_pfx, pfx_err
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_pfx, pfx_err
  );

endinterface

// File: rtl/imm_ext_unit.sv
// rtl/imm_ext_unit.sv - combinational 4-to-16 immediate extender selected by mode
module imm_ext_unit
  import imm_ext_ctrl_pkg::*;
(
  input  logic [3:0]       imm4,
  input  imm_mode_t        mode,
  output logic [IMM_W-1:0] imm
);

  logic [IMM_W-1:0] sext;

  assign sext = {{(IMM_W-4){imm4[3]}}, imm4};

  // PREFIX never reaches the output register through this path; emit zero
  always_comb begin
    imm = '0;
    case (mode)
      ZERO:     imm = {{(IMM_W-4){1'b0}}, imm4};
      SIGN:     imm = sext;
      SIGN_SH1: imm = {sext[IMM_W-2:0], 1'b0};
      default:  imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_ctrl.sv
// rtl/imm_ext_ctrl.sv - decode-stage immediate controller with prefix FSM and ID/EX output register
module imm_ext_ctrl
  import imm_ext_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  imm_ext_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [11:0]      imm12_q, imm12_d;
  logic             out_valid_q, out_valid_d;
  logic [IMM_W-1:0] out_instr_q, out_instr_d;
  logic [IMM_W-1:0] out_imm_q, out_imm_d;
  logic             out_pfx_q, out_pfx_d;
  logic             pfx_err_q, pfx_err_d;

  logic             in_ready;
  logic             accept;
  logic             is_pfx;
  imm_mode_t        mode;
  logic [IMM_W-1:0] ext_imm;

  // No skid buffer: accept only when the output slot is free or draining
  assign in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign mode     = decode_mode(bus.in_instr[15:12]);
  assign is_pfx   = (mode == PREFIX);

  imm_ext_unit u_ext (
    .imm4 (bus.in_instr[3:0]),
    .mode (mode),
    .imm  (ext_imm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_NORM;
      imm12_q     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_imm_q   <= '0;
      out_pfx_q   <= 1'b0;
      pfx_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      imm12_q     <= imm12_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_imm_q   <= out_imm_d;
      out_pfx_q   <= out_pfx_d;
      pfx_err_q   <= pfx_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    imm12_d     = imm12_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_imm_d   = out_imm_q;
    out_pfx_d   = out_pfx_q;
    pfx_err_d   = 1'b0;

    if (bus.flush) begin
      state_d     = S_NORM;
      imm12_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end

      if (accept) begin
        if (is_pfx) begin
          // A prefix only updates the held upper bits; it never produces output
          imm12_d   = bus.in_instr[11:0];
          pfx_err_d = (state_q == S_PFX);
          state_d   = S_PFX;
        end else begin
          out_valid_d = 1'b1;
          out_instr_d = bus.in_instr;
          case (state_q)
            S_PFX: begin
              out_imm_d = {imm12_q, bus.in_instr[3:0]};
              out_pfx_d = 1'b1;
              state_d   = S_NORM;
            end
            default: begin
              out_imm_d = ext_imm;
              out_pfx_d = 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_pfx   = out_pfx_q;
  assign bus.pfx_err   = pfx_err_q;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// tb/tb_imm_ext_ctrl.sv - scoreboard bench for imm_ext_ctrl with directed vectors
module tb_imm_ext_ctrl;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        pfx;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pfx_err_cnt;
  exp_t sb[$];

  imm_ext_ctrl_if bus ();

  imm_ext_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed output handshake
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got imm %h with empty queue", bus.out_imm);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", {16'h0, bus.out_instr}, {16'h0, e.instr});
        chk("sb_imm", {16'h0, bus.out_imm}, {16'h0, e.imm});
        chk("sb_pfx", {31'h0, bus.out_pfx}, {31'h0, e.pfx});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus.pfx_err) pfx_err_cnt++;
  end

  // Presents one instruction until accepted; non-prefix words push an expectation
  task automatic send(input logic [15:0] instr, input logic [15:0] exp_imm, input logic exp_pfx);
    int  n;
    bit  acc;
    n = 0;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (!acc) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: instr %h not accepted, got in_ready=0 required 1", instr);
    end else if (instr[15:12] != 4'hF) begin
      exp_t e;
      e.instr = instr;
      e.imm   = exp_imm;
      e.pfx   = exp_pfx;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    pfx_err_cnt  = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out_instr", {16'h0, bus.out_instr}, 32'h0);
    chk("rst_out_imm", {16'h0, bus.out_imm}, 32'h0);
    chk("rst_out_pfx", {31'h0, bus.out_pfx}, 32'h0);
    chk("rst_pfx_err", {31'h0, bus.pfx_err}, 32'h0);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Mode extension, back-to-back
    send(16'h2105, 16'h0005, 1'b0);
    send(16'h210B, 16'hFFFB, 1'b0);
    send(16'h410B, 16'h000B, 1'b0);
    send(16'hC10B, 16'hFFF6, 1'b0);
    send(16'h810F, 16'hFFFF, 1'b0);
    send(16'hE107, 16'h000E, 1'b0);
    idle(3);

    // Prefix then arith: no output after the prefix alone
    send(16'hF123, 16'h0000, 1'b0);
    @(negedge clk);
    chk("pfx_no_output", {31'h0, bus.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    send(16'h2104, 16'h1234, 1'b1);
    idle(3);

    // Prefix with branch: no shift
    send(16'hFABC, 16'h0000, 1'b0);
    send(16'hC10F, 16'hABCF, 1'b1);
    idle(3);

    // Two prefixes: one pfx_err pulse, second prefix wins
    chk("pfx_err_before", pfx_err_cnt, 0);
    send(16'hF111, 16'h0000, 1'b0);
    send(16'hF222, 16'h0000, 1'b0);
    send(16'h2103, 16'h2223, 1'b1);
    idle(3);
    chk("pfx_err_once", pfx_err_cnt, 1);

    // Stall: hold out_ready low for 3 cycles
    bus.out_ready = 1'b0;
    send(16'h2105, 16'h0005, 1'b0);
    fork
      send(16'h4107, 16'h0007, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", {31'h0, bus.out_valid}, 32'h1);
          chk("stall_imm", {16'h0, bus.out_imm}, 32'h0005);
          chk("stall_in_ready", {31'h0, bus.in_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(3);

    // Flush drops the held prefix and the word presented during flush
    send(16'hF123, 16'h0000, 1'b0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h2107;
    @(negedge clk);
    chk("flush_in_ready", {31'h0, bus.in_ready}, 32'h0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'h0, bus.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    send(16'h2105, 16'h0005, 1'b0);
    idle(3);

    // Reset in place of flush
    send(16'hF123, 16'h0000, 1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send(16'h2105, 16'h0005, 1'b0);
    idle(4);

    chk("sb_drained", sb.size(), 0);
    chk("pfx_err_total", pfx_err_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

endmodule

// File: doc/imm_ext_ctrl.md
# imm_ext_ctrl

Decode-stage immediate controller for the 16-bit pipelined processor. It accepts fetched instructions over a valid/ready handshake and picks the extension mode for the 4-bit immediate field from the opcode. It handles the two-instruction prefix form that builds a full 16-bit immediate. It registers the instruction and the final 16-bit immediate into the ID/EX boundary. It sequences the existing 4-to-16 extension logic and adds prefix state and pipeline stall/flush behaviour.

## Interface
- IMM_W, 16: width of the produced immediate and of the instruction word.
- PFX_OPC, 4'b1111: opcode that marks a prefix instruction.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents an instruction.
- in_instr  input  16  instruction word; fields: opcode [15:12], rd [11:8], rs [7:4], imm4 [3:0].
- in_ready  output  1  block accepts in_instr this cycle.
- flush  input  1  branch-taken squash; discards held prefix and output register.
- out_ready  input  1  ID/EX stage can take the output (low = stall).
- out_valid  output  1  out_instr / out_imm valid.
- out_instr  output  16  registered instruction (non-prefix only).
- out_imm  output  16  final immediate.
- out_pfx  output  1  out_imm was built from a prefix.
- pfx_err  output  1  one-cycle pulse: a prefix followed a prefix.

## Operation
- Extension mode is decided from in_instr[15:12]:
  - 0000–0011 (arith) → SIGN: {{12{imm4[3]}}, imm4}.
  - 0100–0111 (logic) → ZERO: {12'b0, imm4}.
  - 1000–1011 (load/store offset) → SIGN.
  - 1100–1110 (branch) → SIGN_SH1: sign-extended, then << 1, result truncated to 16 bits.
  - 1111 → PREFIX.
- FSM states:
  - S_NORM: no prefix held.
  - S_PFX: prefix held; imm12 register = prefix in_instr[11:0].
- Transitions, on an accepted prefix (in_valid & in_ready):
  - S_NORM → S_PFX. No output is produced; out_valid is unchanged by the prefix itself.
  - In S_PFX, a second prefix overwrites imm12, stays in S_PFX and pulses pfx_err for the next cycle.
- On an accepted non-prefix instruction:
  - In S_NORM: output register loads in_instr and the mode-extended imm; out_pfx=0.
  - In S_PFX: out_imm = {imm12, imm4}. Opcode mode is ignored, with no shift even for branch. out_pfx=1. Next state is S_NORM.
- flush (priority over everything except reset):
  - Next cycle out_valid=0 and state=S_NORM.
  - An instruction presented in the flush cycle is dropped.
  - in_ready is forced 0 during flush.

## Timing
- Reset values: out_valid=0, out_instr=0, out_imm=0, out_pfx=0, pfx_err=0, state=S_NORM, imm12=0.
- Reset mid-operation discards the held prefix and the output entry.
- in_ready = !flush & (!out_valid | out_ready). It is combinational; there is no skid buffer.
- Latency: accepted non-prefix instruction appears on the outputs on the next edge (1 cycle).
- Throughput is 1 per cycle when out_ready=1.
- A prefix + instruction pair costs 2 input cycles and yields 1 output.
- Stall: while out_valid & !out_ready, all outputs and state hold stable and in_ready=0.
- A prefix is never accepted while stalled.
- Simultaneous output consumption and new accept: the output register reloads the same edge. out_valid stays 1.
- Output consumed with no new accept: out_valid falls 0 the next cycle.
- pfx_err is high for exactly one cycle, with no stall dependence.

## Structure
- Shared decode package holds:
  - opcode-group constants;
  - PFX_OPC;
  - 2-bit imm_mode_t encodings ZERO=0, SIGN=1, SIGN_SH1=2, PREFIX=3;
  - FSM state encodings.
- One sub-module: imm_ext_unit. It is combinational: (imm4, mode) → 16-bit immediate, and it replaces the standalone extender. The FSM, prefix register and output register live in imm_ext_ctrl.

## Test plan
- Reset, then inputs 0x2105, 0x210B, 0x410B, 0xC10B with out_ready=1 → out_imm 0x0005, 0xFFFB, 0x000B, 0xFFF6 on consecutive cycles; out_pfx=0.
- Prefix 0xF123 then 0x2104 → no output after the prefix; next cycle out_imm=0x1234, out_pfx=1, out_instr=0x2104.
- Prefix with a branch: 0xFABC then 0xC10F → out_imm=0xABCF (no shift).
- Two prefixes: 0xF111, 0xF222, 0x2103 → pfx_err pulses once; out_imm=0x2223.
- Stall: present 0x2105 then 0x4107, hold out_ready=0 for 3 cycles → out_imm holds 0x0005, in_ready=0; on release, 0x0007 follows next cycle.
- Flush after prefix 0xF123, then 0x2105 → out_imm=0x0005 with out_pfx=0. Repeat with reset in place of flush → same result.
